add_sub_pipe: RTL and testbench
===============================

Name: add_sub_pipe

Overview:
- Parametrised, pipelined successor to the 64-bit combinational adder.
- Performs add, subtract, or add-with-carry on WIDTH-bit operands. The carry chain is split into SEG-bit segments, and one segment resolves per pipeline stage.
- Uses valid/ready handshakes on both sides and carries a sideband tag through the pipe. It sits between the operand issue logic and the ALU result mux, and gives a fixed-latency, full-throughput datapath at wide WIDTH.

Parameters:
- WIDTH, 64, operand and result width in bits.
- SEG, 16, bits resolved per stage. WIDTH % SEG must be 0, otherwise elaboration fails. STAGES = WIDTH/SEG.
- TAG_W, 4, width of the opaque sideband tag carried with each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation present on the in_* ports.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  operation select: 00 add, 01 sub (A-B), 10 add with in_cin, 11 reserved (treated as add).
- in_cin  in  1  carry in; used only when in_op=10.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  WIDTH  result bits.
- out_cout  out  1  carry out of the MSB.
- out_ovf  out  1  signed two's-complement overflow.
- out_zero  out  1  out_sum == 0.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (async assert, sync release): all stage valid bits, out_valid and out_* cleared to 0. in_ready = 1 once rst deasserts. In-flight operations are discarded; none emerge after reset.
- Effective operands:
  - add: B' = B, c0 = 0.
  - sub: B' = ~B, c0 = 1.
  - adc: B' = B, c0 = in_cin.
  - reserved: behaves as add.
- Carry convention: out_cout = carry out of A + B' + c0. For sub, cout = 1 means no borrow (A >= B unsigned).
- Overflow: out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- Pipeline: STAGES register stages.
  - Stage k (k = 0..STAGES-1) computes sum bits [k*SEG +: SEG] from the registered segment operands and the carry registered by stage k-1.
  - Stage 0 uses c0.
  - Unresolved upper operand segments and completed lower sum segments are forwarded alongside.
  - Flags are computed in the final stage.
- Advance: enable = !out_valid || out_ready. When enable is 1, every stage shifts by one. When enable is 0, the whole pipe holds, and out_* stay stable while out_valid = 1.
- in_ready = enable (combinational). A transfer occurs when in_valid && in_ready.
- Bubbles: stage valid bits propagate with the data. Bubbles advance and can be squeezed out only through normal advance; no compaction. When enable = 1 and no input transfer occurs, a bubble enters stage 0.
- Latency: an operation transferred at edge N shows out_valid = 1 after edge N+STAGES-1 when no stall occurs, i.e. STAGES cycles including the accept cycle. Stall cycles add 1:1.
- Throughput: 1 operation per cycle while out_ready = 1.
- Ordering: strict FIFO. out_tag always matches the operation's in_tag.
- Simultaneous events: out_ready and in_valid in the same cycle with a full pipe means the result leaves and the new operation enters on the same edge.
- Boundary case SEG = WIDTH: single stage, latency 1.
- Constraint: out_* are registered outputs; no combinational path from in_* to out_*.

Test Plan:
- Directed carry/overflow case (WIDTH=64, SEG=16): add, A=0x7FFFFFFFFFFFFFFF, B=0xE000000000000002 -> sum 0x6000000000000001, cout=1, ovf=0, zero=0, out_valid exactly 4 cycles after accept.
- Positive plus negative: add 3 + 0xFFFFFFFFFFFFFFFF -> sum 2, cout=1, ovf=0. Negative plus negative: add 0xFFFFFFFFFFFFFFFF + 0xFFFFFFFFFFFFFFFE -> sum 0xFFFFFFFFFFFFFFFD, cout=1, ovf=0.
- Overflow: add 0x7FFFFFFFFFFFFFFF + 1 -> sum 0x8000000000000000, ovf=1, cout=0. Sub 0 - 1 -> sum 0xFFFFFFFFFFFFFFFF, cout=0, ovf=0. Sub 5 - 5 -> sum 0, zero=1, cout=1.
- Carry-in and cross-segment ripple: adc, A=0x000000000000FFFF, B=0, cin=1 -> sum 0x0000000000010000. Carry crosses the segment 0 to segment 1 boundary with the correct value.
- Backpressure: stream 10 tagged operations (tags 0..9) back-to-back while out_ready toggles 1,0,0,1,... -> results in tag order, none lost or duplicated, out_* stable while stalled, in_ready == !out_valid || out_ready every cycle.
- Reset mid-flight: accept 3 operations, assert rst for 1 cycle before any completes -> out_valid stays 0 with no stale results afterwards; the next operation returns with normal latency. Repeat with SEG=64 (latency 1) and SEG=8 (latency 8).

Source files
------------

// File: rtl/add_sub_pipe_if.sv
// Valid/ready bundle between the operand issue logic, add_sub_pipe and the ALU result mux.
// The master drives operations and accepts results; the slave is the pipelined adder.
interface add_sub_pipe_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_cin;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );
endinterface

// File: rtl/add_sub_pipe.sv
// Pipelined add / sub / add-with-carry: the carry chain is cut into SEG-bit segments,
// one segment resolves per stage, and the whole pipe advances or holds as a unit.
module add_sub_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    add_sub_pipe_if.slave io
);
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $error("add_sub_pipe: WIDTH must be a multiple of SEG");
    end

    logic             enable;
    logic             xfer;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Stage registers; index k holds the state after segment k has resolved.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    // What each stage sees on its input side, and the segment it resolves.
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_cy;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic [SEG:0]      seg_res [STAGES];
    logic [WIDTH-1:0]  fin_sum;

    assign enable      = !vld_q[LAST] || io.out_ready;
    assign xfer        = io.in_valid && enable;
    assign io.in_ready = enable;

    // Subtraction is A + ~B + 1; the reserved opcode falls through to plain add.
    always_comb begin
        b_eff = io.in_b;
        c0    = 1'b0;
        case (io.in_op)
            2'b01: begin
                b_eff = ~io.in_b;
                c0    = 1'b1;
            end
            2'b10:   c0 = io.in_cin;
            default: c0 = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign src_vld[gi] = xfer;
            assign src_cy[gi]  = c0;
            assign src_a[gi]   = io.in_a;
            assign src_b[gi]   = b_eff;
            assign src_s[gi]   = '0;
            assign src_tag[gi] = io.in_tag;
        end else begin : g_body
            assign src_vld[gi] = vld_q[gi-1];
            assign src_cy[gi]  = cy_q[gi-1];
            assign src_a[gi]   = a_q[gi-1];
            assign src_b[gi]   = b_q[gi-1];
            assign src_s[gi]   = s_q[gi-1];
            assign src_tag[gi] = tag_q[gi-1];
        end

        assign seg_res[gi] = {1'b0, src_a[gi][gi*SEG +: SEG]}
                           + {1'b0, src_b[gi][gi*SEG +: SEG]}
                           + {{SEG{1'b0}}, src_cy[gi]};
    end

    always_comb begin
        fin_sum                    = src_s[LAST];
        fin_sum[LAST*SEG +: SEG]   = seg_res[LAST][SEG-1:0];

        vld_d  = vld_q;
        cy_d   = cy_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            s_d[k]   = s_q[k];
            tag_d[k] = tag_q[k];
        end

        // Bubbles shift with their (don't-care) data; the pipe never compacts.
        if (enable) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k]              = src_vld[k];
                cy_d[k]               = seg_res[k][SEG];
                a_d[k]                = src_a[k];
                b_d[k]                = src_b[k];
                tag_d[k]              = src_tag[k];
                s_d[k]                = src_s[k];
                s_d[k][k*SEG +: SEG]  = seg_res[k][SEG-1:0];
            end
            ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1])
                  && (fin_sum[WIDTH-1] != src_a[LAST][WIDTH-1]);
            zero_d = (fin_sum == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            cy_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            cy_q   <= cy_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign io.out_valid = vld_q[LAST];
    assign io.out_sum   = s_q[LAST];
    assign io.out_cout  = cy_q[LAST];
    assign io.out_ovf   = ovf_q;
    assign io.out_zero  = zero_q;
    assign io.out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe: three instances (SEG = 16, 64, 8) share one operand
// stream; the backpressure section drives only the SEG = 16 instance.
module tb_add_sub_pipe;
    localparam int LAT  [3] = '{4, 1, 8};
    localparam int SEGS [3] = '{16, 64, 8};

    logic clk;
    logic rst;

    logic        drv_valid;
    logic [63:0] drv_a;
    logic [63:0] drv_b;
    logic [1:0]  drv_op;
    logic        drv_cin;
    logic [3:0]  drv_tag;
    logic        drv_ready;
    logic        only16;

    int n_checks;
    int n_errors;

    add_sub_pipe_if #(.WIDTH(64), .TAG_W(4)) if16 ();
    add_sub_pipe_if #(.WIDTH(64), .TAG_W(4)) if64 ();
    add_sub_pipe_if #(.WIDTH(64), .TAG_W(4)) if8 ();

    add_sub_pipe #(.WIDTH(64), .SEG(16), .TAG_W(4)) u16 (.clk(clk), .rst(rst), .io(if16.slave));
    add_sub_pipe #(.WIDTH(64), .SEG(64), .TAG_W(4)) u64 (.clk(clk), .rst(rst), .io(if64.slave));
    add_sub_pipe #(.WIDTH(64), .SEG(8),  .TAG_W(4)) u8  (.clk(clk), .rst(rst), .io(if8.slave));

    assign if16.in_valid  = drv_valid;
    assign if64.in_valid  = drv_valid && !only16;
    assign if8.in_valid   = drv_valid && !only16;
    assign if16.out_ready = drv_ready;
    assign if64.out_ready = drv_ready || only16;
    assign if8.out_ready  = drv_ready || only16;
    assign if16.in_a = drv_a;   assign if64.in_a = drv_a;   assign if8.in_a = drv_a;
    assign if16.in_b = drv_b;   assign if64.in_b = drv_b;   assign if8.in_b = drv_b;
    assign if16.in_op = drv_op; assign if64.in_op = drv_op; assign if8.in_op = drv_op;
    assign if16.in_cin = drv_cin; assign if64.in_cin = drv_cin; assign if8.in_cin = drv_cin;
    assign if16.in_tag = drv_tag; assign if64.in_tag = drv_tag; assign if8.in_tag = drv_tag;

    logic        ov [3];
    logic        ir [3];
    logic [63:0] os [3];
    logic        oc [3];
    logic        oo [3];
    logic        oz [3];
    logic [3:0]  ot [3];

    assign ov[0] = if16.out_valid; assign ov[1] = if64.out_valid; assign ov[2] = if8.out_valid;
    assign ir[0] = if16.in_ready;  assign ir[1] = if64.in_ready;  assign ir[2] = if8.in_ready;
    assign os[0] = if16.out_sum;   assign os[1] = if64.out_sum;   assign os[2] = if8.out_sum;
    assign oc[0] = if16.out_cout;  assign oc[1] = if64.out_cout;  assign oc[2] = if8.out_cout;
    assign oo[0] = if16.out_ovf;   assign oo[1] = if64.out_ovf;   assign oo[2] = if8.out_ovf;
    assign oz[0] = if16.out_zero;  assign oz[1] = if64.out_zero;  assign oz[2] = if8.out_zero;
    assign ot[0] = if16.out_tag;   assign ot[1] = if64.out_tag;   assign ot[2] = if8.out_tag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One operation through all three instances with an otherwise empty pipe.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                          input logic cin, input logic [3:0] tag, input logic [63:0] e_sum,
                          input logic e_cout, input logic e_ovf, input logic e_zero);
        logic [2:0] got;
        int cyc;
        drv_valid = 1'b1; drv_a = a; drv_b = b; drv_op = op; drv_cin = cin; drv_tag = tag;
        drv_ready = 1'b1;
        $display("op tag=%0d op=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d zero=%0d",
                 tag, op, a, b, cin, e_sum, e_cout, e_ovf, e_zero);
        @(posedge clk); #1;
        drv_valid = 1'b0;
        got = '0;
        cyc = 1;
        while (got != 3'b111 && cyc <= 12) begin
            for (int d = 0; d < 3; d++) begin
                if (!got[d] && ov[d]) begin
                    got[d] = 1'b1;
                    chk($sformatf("sum seg%0d tag%0d", SEGS[d], tag), os[d], e_sum);
                    chk($sformatf("cout seg%0d tag%0d", SEGS[d], tag), 64'(oc[d]), 64'(e_cout));
                    chk($sformatf("ovf seg%0d tag%0d", SEGS[d], tag), 64'(oo[d]), 64'(e_ovf));
                    chk($sformatf("zero seg%0d tag%0d", SEGS[d], tag), 64'(oz[d]), 64'(e_zero));
                    chk($sformatf("tag seg%0d tag%0d", SEGS[d], tag), 64'(ot[d]), 64'(tag));
                    chk($sformatf("latency seg%0d tag%0d", SEGS[d], tag), 64'(cyc), 64'(LAT[d]));
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        for (int d = 0; d < 3; d++) begin
            if (!got[d]) chk($sformatf("timeout seg%0d tag%0d", SEGS[d], tag), 64'(0), 64'(1));
            chk($sformatf("drained seg%0d tag%0d", SEGS[d], tag), 64'(ov[d]), 64'(0));
        end
    endtask

    logic [63:0] exp_sum [10];
    logic [63:0] held_sum;
    logic [3:0]  held_tag;
    logic        held;
    int          nsent;
    int          nres;
    int          stale;

    initial begin
        n_checks = 0; n_errors = 0;
        drv_valid = 1'b0; drv_a = '0; drv_b = '0; drv_op = 2'b00; drv_cin = 1'b0;
        drv_tag = '0; drv_ready = 1'b0; only16 = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("reset valid seg%0d", SEGS[d]), 64'(ov[d]), 64'(0));
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset in_ready seg%0d", SEGS[d]), 64'(ir[d]), 64'(1));
            chk($sformatf("reset sum seg%0d", SEGS[d]), os[d], 64'(0));
            chk($sformatf("reset zero seg%0d", SEGS[d]), 64'(oz[d]), 64'(0));
            chk($sformatf("reset tag seg%0d", SEGS[d]), 64'(ot[d]), 64'(0));
        end
        @(posedge clk); #1;

        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hE000_0000_0000_0002, 2'b00, 1'b0, 4'd1,
               64'h6000_0000_0000_0001, 1'b1, 1'b0, 1'b0);
        run_op(64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 4'd2,
               64'h2, 1'b1, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0, 4'd3,
               64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0, 4'd4,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_op(64'h0, 64'h1, 2'b01, 1'b0, 4'd5,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op(64'h5, 64'h5, 2'b01, 1'b0, 4'd6,
               64'h0, 1'b1, 1'b0, 1'b1);
        run_op(64'h0000_0000_0000_FFFF, 64'h0, 2'b10, 1'b1, 4'd7,
               64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 2'b01, 1'b0, 4'd8,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op(64'h1, 64'h1, 2'b11, 1'b1, 4'd9,
               64'h2, 1'b0, 1'b0, 1'b0);
        run_op(64'hFF, 64'h1, 2'b00, 1'b1, 4'd10,
               64'h100, 1'b0, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'b10, 1'b1, 4'd11,
               64'h0, 1'b1, 1'b0, 1'b1);
        run_op(64'h0000_0001_0000_0000, 64'h1, 2'b01, 1'b0, 4'd12,
               64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Backpressure on the SEG=16 instance: out_ready follows 1,0,0,1,0,0,...
        only16 = 1'b1;
        nsent = 0; nres = 0; held = 1'b0; held_sum = '0; held_tag = '0;
        for (int cyc = 0; cyc < 60 && nres < 10; cyc++) begin
            drv_ready = (cyc % 3 == 0);
            if (nsent < 10) begin
                drv_valid = 1'b1;
                drv_a     = 64'h0000_FFFF_FFFF_FFF0 + 64'(nsent);
                drv_b     = 64'h0000_0000_0000_0010 + 64'(nsent);
                drv_op    = (nsent % 2 == 1) ? 2'b01 : 2'b00;
                drv_cin   = 1'b0;
                drv_tag   = 4'(nsent);
                exp_sum[nsent] = (nsent % 2 == 1) ? drv_a - drv_b : drv_a + drv_b;
            end else begin
                drv_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk($sformatf("stall valid cyc%0d", cyc), 64'(if16.out_valid), 64'(1));
                chk($sformatf("stall sum cyc%0d", cyc), if16.out_sum, held_sum);
                chk($sformatf("stall tag cyc%0d", cyc), 64'(if16.out_tag), 64'(held_tag));
            end
            chk($sformatf("in_ready cyc%0d", cyc), 64'(if16.in_ready),
                64'(!if16.out_valid || drv_ready));
            if (if16.out_valid && drv_ready) begin
                $display("bp result tag=%0d sum=%h", if16.out_tag, if16.out_sum);
                chk($sformatf("bp tag order %0d", nres), 64'(if16.out_tag), 64'(nres));
                chk($sformatf("bp sum %0d", nres), if16.out_sum, exp_sum[nres]);
                nres++;
            end
            held     = if16.out_valid && !drv_ready;
            held_sum = if16.out_sum;
            held_tag = if16.out_tag;
            if (drv_valid && if16.in_ready) nsent++;
            @(posedge clk); #1;
        end
        drv_valid = 1'b0;
        chk("bp result count", 64'(nres), 64'(10));
        chk("bp sent count", 64'(nsent), 64'(10));
        only16 = 1'b0;
        drv_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Reset with three operations in flight: nothing stale may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            drv_valid = 1'b1;
            drv_a = 64'h1234 + 64'(i); drv_b = 64'h1; drv_op = 2'b00; drv_cin = 1'b0;
            drv_tag = 4'(13 + i);
            $display("inflight tag=%0d a=%h b=%h", drv_tag, drv_a, drv_b);
            @(posedge clk); #1;
        end
        drv_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("midflight rst valid seg%0d", SEGS[d]), 64'(ov[d]), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            for (int d = 0; d < 3; d++) if (ov[d]) stale++;
            @(posedge clk); #1;
        end
        chk("stale results after reset", 64'(stale), 64'(0));

        run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 2'b00, 1'b0, 4'd15,
               64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
